// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Frames parallel words into an asynchronous serial bit stream for an RS422
//   line driver. It runs downstream of a baud generator: it raises baud_en_o
//   while a frame is in flight, and it moves on by one bit on every baud_tick_i.
//   The idle line level is mark (high). The frame is sent LSB first:
//   start, data, optional parity, then one or two stop bits.
//
// Parameters
//   DATA_BITS   payload bits per frame (5..9)
//   PARITY_EN   1 = append a parity bit after the data bits
//   PARITY_ODD  1 = odd parity, 0 = even (ignored without parity)
//   STOP_BITS   stop bits per frame (1 or 2)
//
// Ports
//   clk_i        single clock, rising edge
//   rst_ni       synchronous active-low reset
//   baud_tick_i  one-clock pulse per bit period from the baud generator
//   baud_en_o    baud generator enable, high while a frame is in flight
//   tx_data_i    word to send, sampled only on the handshake
//   tx_valid_i   upstream offers tx_data_i
//   tx_ready_o   a word can be accepted this cycle
//   tx_out_o     serial line output
//   tx_busy_o    high from acceptance until the last stop bit completes

module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 baud_tick_i,
  output logic                 baud_en_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_out_o,
  output logic                 tx_busy_o
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic ODD_BIT   = (PARITY_ODD != 0);
  localparam logic HAS_PAR   = (PARITY_EN != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  // Bad parameter values stop elaboration instead of producing a broken frame.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_serializer: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY_EN and PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [CNT_W-1:0]     bit_cnt_d;
  logic                 stop_cnt_q;
  logic                 parity_q;
  logic                 parity_d;
  logic                 tx_out_q;
  logic                 tx_ready_q;
  logic                 tx_busy_q;
  logic                 baud_en_q;

  // Next values for the data path. Parity is taken from the incoming word,
  // because it is only loaded on the handshake edge.
  assign shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
  assign bit_cnt_d = bit_cnt_q + 1'b1;
  assign parity_d  = (^tx_data_i) ^ ODD_BIT;

  // Frame sequencer. Every output is registered, so the line changes on the
  // same edge that changes the state. Outside IDLE, the state changes only on
  // a baud tick. In IDLE the tick is ignored: the generator restarts when
  // baud_en rises, so the start bit lasts a full period.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      baud_en_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_valid_i && tx_ready_q) begin
            shift_q    <= tx_data_i;
            parity_q   <= parity_d;
            tx_out_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b1;
            baud_en_q  <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (baud_tick_i) begin
            tx_out_q  <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick_i) begin
            if (bit_cnt_q == LAST_BIT) begin
              if (HAS_PAR) begin
                tx_out_q <= parity_q;
                state_q  <= PARITY;
              end else begin
                tx_out_q   <= 1'b1;
                stop_cnt_q <= 1'b0;
                state_q    <= STOP;
              end
            end else begin
              // The bit that follows is shift_q[1], so the line is loaded
              // with it on the same edge as the shift.
              shift_q   <= shift_d;
              tx_out_q  <= shift_q[1];
              bit_cnt_q <= bit_cnt_d;
            end
          end
        end
        PARITY: begin
          if (baud_tick_i) begin
            tx_out_q   <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= STOP;
          end
        end
        STOP: begin
          if (baud_tick_i) begin
            if (stop_cnt_q == STOP_LAST) begin
              tx_out_q   <= 1'b1;
              tx_ready_q <= 1'b1;
              tx_busy_q  <= 1'b0;
              baud_en_q  <= 1'b0;
              state_q    <= IDLE;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_out_q   <= 1'b1;
          tx_ready_q <= 1'b1;
          tx_busy_q  <= 1'b0;
          baud_en_q  <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_out_o   = tx_out_q;
  assign tx_ready_o = tx_ready_q;
  assign tx_busy_o  = tx_busy_q;
  assign baud_en_o  = baud_en_q;

endmodule
